// File: rtl/hash_io_if.sv
// Host-side word I/O front end for hash cores: packs host words into core blocks
// (double-buffered, valid/ready toward the core) and serves the captured digest word by word.
//
// state    | meaning
// S_IDLE   | out of reset, waiting for init
// S_ABSORB | accepting message words
// S_DRAIN  | final block packed, waiting for the digest
// S_DIGEST | digest captured, fetches served
module hash_io_if #(
  parameter int IO_W  = 16,
  parameter int BLK_W = 32,
  parameter int DIG_W = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_init,
  input  logic             i_load,
  input  logic             i_last,
  input  logic             i_fetch,
  input  logic [IO_W-1:0]  i_idata,
  output logic             o_ack,
  output logic [IO_W-1:0]  o_odata,
  output logic             o_err,
  output logic             o_core_init,
  output logic [BLK_W-1:0] o_core_blk,
  output logic             o_core_blk_last,
  output logic             o_core_blk_valid,
  input  logic             i_core_blk_ready,
  input  logic [DIG_W-1:0] i_core_dig,
  input  logic             i_core_dig_valid
);

  localparam int NW   = BLK_W / IO_W;
  localparam int ND   = DIG_W / IO_W;
  localparam int NW_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int ND_W = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_DRAIN, S_DIGEST} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BLK_W-1:0] r_pack;
  logic             r_pack_last;
  logic [NW_W-1:0]  r_wcnt;
  logic [BLK_W-1:0] r_out;
  logic             r_out_last;
  logic             r_out_valid;
  logic [DIG_W-1:0] r_dig;
  logic [ND_W-1:0]  r_fptr;
  logic [IO_W-1:0]  r_odata;
  logic             r_ack;
  logic             r_err;
  logic             r_core_init;

  logic             w_stall;
  logic             w_accept;
  logic             w_done;
  logic             w_serve;
  logic             w_err;
  logic             w_dig_cap;
  logic [BLK_W-1:0] w_pack_nxt;
  logic             w_last_nxt;
  logic [ND_W-1:0]  w_dig_idx;
  logic [DIG_W-1:0] w_dig_shift;
  logic [IO_W-1:0]  w_dig_word;

  // The completing word is held off while the output buffer is full and not draining,
  // so an accepted final word always moves its block out on the same edge.
  assign w_stall    = (r_wcnt == NW_W'(NW - 1)) && r_out_valid && !i_core_blk_ready;
  assign w_accept   = i_load && !i_fetch && !r_ack && !i_init && (r_state == S_ABSORB) && !w_stall;
  assign w_done     = w_accept && (r_wcnt == NW_W'(NW - 1));
  assign w_serve    = i_fetch && !i_load && !r_ack && !i_init && (r_state == S_DIGEST);
  assign w_err      = !i_init && i_load && (i_fetch || (r_state != S_ABSORB));
  assign w_dig_cap  = i_core_dig_valid && !i_init && ((r_state == S_ABSORB) || (r_state == S_DRAIN));
  assign w_pack_nxt = (r_pack << IO_W) | BLK_W'(i_idata);
  assign w_last_nxt = r_pack_last | i_last;

  assign w_dig_idx   = ND_W'(ND - 1) - r_fptr;
  assign w_dig_shift = r_dig >> (w_dig_idx * IO_W);
  assign w_dig_word  = w_dig_shift[IO_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_init) begin
      w_state_nxt = S_ABSORB;
    end else begin
      case (r_state)
        S_ABSORB: begin
          if (i_core_dig_valid)        w_state_nxt = S_DIGEST;
          else if (w_done && w_last_nxt) w_state_nxt = S_DRAIN;
        end
        S_DRAIN:  if (i_core_dig_valid) w_state_nxt = S_DIGEST;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pack      <= '0;
      r_pack_last <= 1'b0;
      r_wcnt      <= '0;
      r_out       <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_dig       <= '0;
      r_fptr      <= '0;
      r_odata     <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_core_init <= 1'b0;
    end else begin
      r_ack       <= w_accept | w_serve;
      r_err       <= w_err;
      r_core_init <= i_init;
      if (i_init) begin
        r_pack      <= '0;
        r_pack_last <= 1'b0;
        r_wcnt      <= '0;
        r_out_valid <= 1'b0;
        r_fptr      <= '0;
      end else begin
        if (r_out_valid && i_core_blk_ready) r_out_valid <= 1'b0;
        if (w_done) begin
          r_out       <= w_pack_nxt;
          r_out_last  <= w_last_nxt;
          r_out_valid <= 1'b1;
          r_pack      <= '0;
          r_pack_last <= 1'b0;
          r_wcnt      <= '0;
        end else if (w_accept) begin
          r_pack      <= w_pack_nxt;
          r_pack_last <= w_last_nxt;
          r_wcnt      <= r_wcnt + NW_W'(1);
        end
        if (w_dig_cap) begin
          r_dig  <= i_core_dig;
          r_fptr <= '0;
        end else if (w_serve) begin
          r_odata <= w_dig_word;
          r_fptr  <= (r_fptr == ND_W'(ND - 1)) ? '0 : r_fptr + ND_W'(1);
        end
      end
    end
  end

  assign o_ack            = r_ack;
  assign o_odata          = r_odata;
  assign o_err            = r_err;
  assign o_core_init      = r_core_init;
  assign o_core_blk       = r_out;
  assign o_core_blk_last  = r_out_last;
  assign o_core_blk_valid = r_out_valid;

endmodule

// File: tb/tb_hash_io_if.sv
// Directed bench for hash_io_if: block and digest-word scoreboards, immediate-assertion checks.
module tb_hash_io_if;

  logic         clk = 1'b0;
  logic         rst_n, init, load, last, fetch, ready, dig_valid;
  logic [15:0]  idata;
  logic [255:0] dig;
  logic         ack, err, core_init, blk_last, blk_valid;
  logic [15:0]  odata;
  logic [31:0]  blk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [32:0] blk_q[$];
  logic [15:0] word_q[$];
  logic [15:0] dwords[16];
  logic [15:0] e;

  always #5 clk = ~clk;

  hash_io_if #(.IO_W(16), .BLK_W(32), .DIG_W(256)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init), .i_load(load), .i_last(last),
    .i_fetch(fetch), .i_idata(idata), .o_ack(ack), .o_odata(odata), .o_err(err),
    .o_core_init(core_init), .o_core_blk(blk), .o_core_blk_last(blk_last),
    .o_core_blk_valid(blk_valid), .i_core_blk_ready(ready), .i_core_dig(dig),
    .i_core_dig_valid(dig_valid)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one-cycle load pulse, then one idle cycle; returns the ack seen after the edge
  task automatic load_word(input logic [15:0] d, input logic l, input logic exp_ack, input string tag);
    load = 1'b1; idata = d; last = l;
    tick();
    load = 1'b0; last = 1'b0;
    chk(tag, ack, exp_ack);
    tick();
  endtask

  task automatic pulse_init;
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
  endtask

  // block scoreboard: a block is consumed on the edge following a cycle with valid & ready
  always @(negedge clk) begin
    if (rst_n && blk_valid && ready) begin
      logic [32:0] b;
      chk("blk_expected", 256'(blk_q.size() != 0), 256'(1));
      b = (blk_q.size() != 0) ? blk_q.pop_front() : 33'h0;
      chk("core_blk", blk, b[31:0]);
      chk("core_blk_last", blk_last, b[32]);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      dwords[i] = 16'h0011 + 16'(i * 16'h2222);
      dig[255 - 16*i -: 16] = dwords[i];
    end
    rst_n = 1'b0; init = 0; load = 0; last = 0; fetch = 0; ready = 0; dig_valid = 0; idata = '0;
    tick(); tick(); tick();
    chk("rst_ack", ack, 0);
    chk("rst_odata", odata, 0);
    chk("rst_err", err, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_core_init", core_init, 0);
    rst_n = 1'b1;
    tick();

    // load in IDLE is a protocol error
    load = 1'b1; idata = 16'hDEAD;
    tick();
    load = 1'b0;
    chk("idle_load_err", err, 1);
    chk("idle_load_ack", ack, 0);
    tick();

    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_pulse", core_init, 1);
    chk("init_ack", ack, 0);
    chk("init_err", err, 0);
    chk("init_blk_valid", blk_valid, 0);
    tick();
    chk("init_pulse_end", core_init, 0);

    // single block, core ready
    ready = 1'b1;
    blk_q.push_back({1'b0, 32'h1234ABCD});
    load_word(16'h1234, 1'b0, 1'b1, "ld1_ack");
    load = 1'b1; idata = 16'hABCD;
    tick();
    load = 1'b0;
    chk("ld2_ack", ack, 1);
    chk("blk1_valid", blk_valid, 1);
    tick();
    chk("blk1_consumed", blk_valid, 0);

    // backpressure: fourth word stalls until the first block drains
    ready = 1'b0;
    blk_q.push_back({1'b0, 32'h00010002});
    blk_q.push_back({1'b0, 32'h00030004});
    load_word(16'h0001, 1'b0, 1'b1, "bp1_ack");
    load_word(16'h0002, 1'b0, 1'b1, "bp2_ack");
    load_word(16'h0003, 1'b0, 1'b1, "bp3_ack");
    load = 1'b1; idata = 16'h0004;
    tick();
    chk("bp4_stall_ack", ack, 0);
    tick();
    chk("bp4_stall_ack2", ack, 0);
    chk("bp_hold_valid", blk_valid, 1);
    chk("bp_hold_blk", blk, 32'h00010002);
    ready = 1'b1;
    tick();
    load = 1'b0;
    chk("bp4_ack", ack, 1);
    chk("bp_blk2_valid", blk_valid, 1);
    tick();
    chk("bp_blk2_consumed", blk_valid, 0);

    // init after one word discards the partial block
    load_word(16'h5555, 1'b0, 1'b1, "mid_ld_ack");
    pulse_init();
    blk_q.push_back({1'b0, 32'h66667777});
    load_word(16'h6666, 1'b0, 1'b1, "fresh1_ack");
    load_word(16'h7777, 1'b0, 1'b1, "fresh2_ack");

    // final block, then loads are refused
    pulse_init();
    blk_q.push_back({1'b1, 32'h11112222});
    load_word(16'h1111, 1'b0, 1'b1, "fin1_ack");
    load_word(16'h2222, 1'b1, 1'b1, "fin2_ack");
    load = 1'b1; idata = 16'h3333;
    tick();
    load = 1'b0;
    chk("drain_load_err", err, 1);
    chk("drain_load_ack", ack, 0);
    tick();
    chk("err_pulse_end", err, 0);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("drain_fetch_ack", ack, 0);
    chk("drain_fetch_err", err, 0);
    tick();

    // digest capture and readout with wrap
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) begin
      fetch = 1'b1;
      word_q.push_back(dwords[i % 16]);
      tick();
      fetch = 1'b0;
      chk("fetch_ack", ack, 1);
      e = word_q.pop_front();
      chk("fetch_data", odata, e);
      tick();
      chk("odata_hold", odata, e);
    end

    load = 1'b1; fetch = 1'b1;
    tick();
    load = 1'b0; fetch = 1'b0;
    chk("ldfetch_err", err, 1);
    chk("ldfetch_ack", ack, 0);
    chk("ldfetch_odata", odata, dwords[0]);
    tick();
    fetch = 1'b1;
    word_q.push_back(dwords[1]);
    tick();
    fetch = 1'b0;
    chk("after_err_ack", ack, 1);
    chk("after_err_data", odata, word_q.pop_front());
    tick();

    // digest strobe coincident with init is dropped
    init = 1'b1; dig_valid = 1'b1;
    tick();
    init = 1'b0; dig_valid = 1'b0;
    tick();
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("init_dig_fetch_ack", ack, 0);
    tick();

    // reset while in DIGEST
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("pre_rst_fetch", odata, dwords[0]);
    rst_n = 1'b0;
    tick();
    chk("rst2_ack", ack, 0);
    chk("rst2_odata", odata, 0);
    chk("rst2_err", err, 0);
    chk("rst2_core_init", core_init, 0);
    chk("rst2_blk_valid", blk_valid, 0);
    chk("rst2_blk", blk, 0);
    rst_n = 1'b1;
    tick();
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("idle_fetch_ack", ack, 0);
    tick();

    chk("blk_q_empty", 256'(blk_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
